uart_alu_sequencer: RTL and testbench
=====================================

Name: uart_alu_sequencer

Overview:
- Command sequencer between the UART receiver, the ALU and the UART transmitter.
- Collects three received bytes in order: operand A, operand B, opcode.
- Presents them to the combinational ALU, then hands the ALU result byte to the transmitter and waits for that transmission to complete.
- An inter-byte timeout discards partially received commands.

Parameters:
DATA_WIDTH, 8, width of operands, result and UART data byte
OP_WIDTH, 6, opcode width; taken from the low OP_WIDTH bits of the third byte
TIMEOUT_CYCLES, 100000, max clock cycles between bytes of one command; 0 disables the timeout

Ports:
i_clock  in  1  system clock; all logic on rising edge
i_reset  in  1  synchronous, active-high reset
i_rx_done  in  1  one-cycle pulse; i_rx_data valid in the same cycle
i_rx_data  in  DATA_WIDTH  received byte
i_alu_result  in  DATA_WIDTH  combinational ALU output for o_alu_a/o_alu_b/o_alu_op
i_tx_done  in  1  one-cycle pulse from transmitter when the stop bit has completed
o_alu_a  out  DATA_WIDTH  registered operand A
o_alu_b  out  DATA_WIDTH  registered operand B
o_alu_op  out  OP_WIDTH  registered opcode
o_tx_start  out  1  one-cycle pulse requesting transmission of o_tx_data
o_tx_data  out  DATA_WIDTH  registered result byte for the transmitter
o_busy  out  1  high from COMPUTE through WAIT_TX
o_timeout  out  1  one-cycle pulse when a partial command is discarded

Behaviour:
- Reset:
  - state = WAIT_A.
  - o_alu_a, o_alu_b, o_alu_op, o_tx_data = 0.
  - o_tx_start, o_busy, o_timeout = 0.
  - Timeout counter = 0.
  - Reset has priority over every event; reset mid-command or mid-transmission returns to WAIT_A with no o_tx_start.
- States (binary or one-hot): WAIT_A, WAIT_B, WAIT_OP, COMPUTE, SEND, WAIT_TX.
- WAIT_A: on i_rx_done, o_alu_a <= i_rx_data, go to WAIT_B, clear counter. Otherwise stay; counter held at 0.
- WAIT_B: on i_rx_done, o_alu_b <= i_rx_data, go to WAIT_OP, clear counter. Otherwise counter increments.
- WAIT_OP: on i_rx_done, o_alu_op <= i_rx_data[OP_WIDTH-1:0], go to COMPUTE. Otherwise counter increments.
- Timeout (WAIT_B/WAIT_OP only, TIMEOUT_CYCLES > 0):
  - When the counter equals TIMEOUT_CYCLES-1 and i_rx_done is low: go to WAIT_A, pulse o_timeout for 1 cycle, clear counter.
  - Operand registers keep their stale values.
  - If i_rx_done coincides with the terminal count, the byte is accepted and no timeout occurs.
- COMPUTE: exactly 1 cycle; ALU inputs stable. At its end, o_tx_data <= i_alu_result; go to SEND.
- SEND: exactly 1 cycle; o_tx_start = 1 (registered, high only in this cycle); go to WAIT_TX.
- WAIT_TX: stay until i_tx_done, then go to WAIT_A.
- i_tx_done outside WAIT_TX is ignored.
- Latency: opcode i_rx_done at edge T → COMPUTE during T+1 → o_tx_start high and o_tx_data valid during T+2.
- o_busy = 1 in COMPUTE, SEND, WAIT_TX; 0 otherwise.
- i_rx_done in COMPUTE, SEND or WAIT_TX is dropped: no register changes, and it does not count as byte A of the next command.
- o_alu_a/b/op and o_tx_data hold their values until overwritten; they are never cleared except by reset.
- Counter width: clog2(TIMEOUT_CYCLES+1) bits; it never wraps, because it is cleared at terminal count.
- Back-to-back commands: a new A byte is accepted in the first WAIT_A cycle after i_tx_done.

Test Plan:
- Nominal (bench ALU = A+B mod 256): bytes 0x05, 0x03, 0x20 → o_alu_op=0x20, o_tx_start pulse 2 cycles after third i_rx_done with o_tx_data=0x08; i_tx_done → o_busy falls, state WAIT_A.
- Opcode masking and wrap: bytes 0xF0, 0x20, 0xE2 → o_alu_op=0x22, o_tx_data=0x10 (bench sum wraps); exactly one o_tx_start pulse.
- Timeout (TIMEOUT_CYCLES=16): byte 0x11 then silence → o_timeout pulse 16 cycles after that byte. Then 0x01, 0x02, 0x20 → o_tx_data=0x03 (0x11 discarded).
- Timeout boundary: i_rx_done on the terminal-count cycle in WAIT_B → byte accepted, no o_timeout, state WAIT_OP.
- Busy drop: i_rx_done with 0x55 during WAIT_TX → ignored. After i_tx_done, bytes 0x02, 0x02, 0x20 → o_tx_data=0x04.
- Reset mid-command: assert i_reset for 1 cycle in WAIT_OP → all outputs 0, no o_tx_start; next full command completes normally.

Source files
------------

// File: rtl/uart_alu_sequencer.sv
// uart_alu_sequencer: gathers A, B and opcode bytes from the UART receiver,
// drives the ALU, then hands the result byte to the UART transmitter.
module uart_alu_sequencer #(
    parameter int DATA_WIDTH     = 8,
    parameter int OP_WIDTH       = 6,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_timeout
);

    // A zero-width counter is not legal, so keep one bit when disabled.
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        WAIT_A,
        WAIT_B,
        WAIT_OP,
        COMPUTE,
        SEND,
        WAIT_TX
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q, busy_d;
    logic                  timeout_q, timeout_d;
    logic                  terminal;
    logic                  unused_rx_hi;

    // Only the low opcode bits of the third byte are meaningful.
    always_comb unused_rx_hi = ^i_rx_data;

    // Terminal count of the inter-byte timer; never true when disabled.
    always_comb terminal = (TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST);

    // Next-state, operand capture, timeout and registered output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        timeout_d = 1'b0;
        unique case (state_q)
            WAIT_A: begin
                cnt_d = '0;
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = WAIT_OP;
                    cnt_d   = '0;
                end else if (terminal) begin
                    state_d   = WAIT_A;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[OP_WIDTH-1:0];
                    state_d  = COMPUTE;
                    cnt_d    = '0;
                end else if (terminal) begin
                    state_d   = WAIT_A;
                    timeout_d = 1'b1;
                    cnt_d     = '0;
                end else if (TIMEOUT_CYCLES > 0) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            COMPUTE: begin
                tx_data_d = i_alu_result;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
                cnt_d   = '0;
            end
        endcase
        tx_start_d = (state_d == SEND);
        busy_d     = (state_d == COMPUTE) || (state_d == SEND) ||
                     (state_d == WAIT_TX);
    end

    // State and output registers; reset wins over every other event.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q    <= WAIT_A;
            cnt_q      <= '0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_alu_sequencer.sv
// tb_uart_alu_sequencer: directed vectors and corner-case sequences
// for the UART/ALU command sequencer, using an adder as the ALU.
module tb_uart_alu_sequencer;

    localparam int DW = 8;
    localparam int OW = 6;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_done = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic [DW-1:0] alu_result;
    logic          tx_done = 1'b0;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [OW-1:0] alu_op;
    logic          tx_start;
    logic [DW-1:0] tx_data;
    logic          busy;
    logic          timeout;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] opb;
        logic [5:0] exp_op;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    // Bench ALU: plain 8-bit sum.
    assign alu_result = alu_a + alu_b;

    uart_alu_sequencer #(
        .DATA_WIDTH    (DW),
        .OP_WIDTH      (OW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_rx_done   (rx_done),
        .i_rx_data   (rx_data),
        .i_alu_result(alu_result),
        .i_tx_done   (tx_done),
        .o_alu_a     (alu_a),
        .o_alu_b     (alu_b),
        .o_alu_op    (alu_op),
        .o_tx_start  (tx_start),
        .o_tx_data   (tx_data),
        .o_busy      (busy),
        .o_timeout   (timeout)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        rx_done = 1'b1;
        rx_data = d;
        tick();
        rx_done = 1'b0;
        rx_data = '0;
    endtask

    // Sends a full command and checks it up to the WAIT_TX state.
    task automatic run_cmd(input string name, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] opb,
                           input logic [5:0] exp_op, input logic [7:0] exp_tx);
        send_byte(a);
        chk({name, " a"}, 32'(alu_a), 32'(a));
        send_byte(b);
        chk({name, " b"}, 32'(alu_b), 32'(b));
        send_byte(opb);
        chk({name, " op"}, 32'(alu_op), 32'(exp_op));
        chk({name, " busy@compute"}, 32'(busy), 32'd1);
        chk({name, " start@compute"}, 32'(tx_start), 32'd0);
        tick();
        chk({name, " start@send"}, 32'(tx_start), 32'd1);
        chk({name, " tx_data"}, 32'(tx_data), 32'(exp_tx));
        tick();
        chk({name, " start@wait"}, 32'(tx_start), 32'd0);
        chk({name, " busy@wait"}, 32'(busy), 32'd1);
        tick();
        chk({name, " start single"}, 32'(tx_start), 32'd0);
    endtask

    task automatic finish_tx(input string name);
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk({name, " busy@done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        vecs[0] = '{a: 8'h05, b: 8'h03, opb: 8'h20, exp_op: 6'h20, exp_tx: 8'h08};
        vecs[1] = '{a: 8'hF0, b: 8'h20, opb: 8'hE2, exp_op: 6'h22, exp_tx: 8'h10};
        vecs[2] = '{a: 8'h02, b: 8'h02, opb: 8'h20, exp_op: 6'h20, exp_tx: 8'h04};
        vecs[3] = '{a: 8'hFF, b: 8'h01, opb: 8'h3F, exp_op: 6'h3F, exp_tx: 8'h00};
        vecs[4] = '{a: 8'h7F, b: 8'h80, opb: 8'hC0, exp_op: 6'h00, exp_tx: 8'hFF};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst a", 32'(alu_a), 32'd0);
        chk("rst b", 32'(alu_b), 32'd0);
        chk("rst op", 32'(alu_op), 32'd0);
        chk("rst tx_data", 32'(tx_data), 32'd0);
        chk("rst start", 32'(tx_start), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);

        // Stray tx_done while idle must have no effect.
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        chk("idle tx_done busy", 32'(busy), 32'd0);

        for (int i = 0; i < 5; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].a, vecs[i].b,
                    vecs[i].opb, vecs[i].exp_op, vecs[i].exp_tx);
            finish_tx($sformatf("vec%0d", i));
        end

        // Timeout after the A byte: pulse lands 16 edges later.
        send_byte(8'h11);
        for (int k = 1; k <= TO; k++) begin
            tick();
            chk($sformatf("to wait%0d", k), 32'(timeout), (k == TO) ? 32'd1 : 32'd0);
        end
        tick();
        chk("to pulse end", 32'(timeout), 32'd0);
        run_cmd("after_to", 8'h01, 8'h02, 8'h20, 6'h20, 8'h03);
        finish_tx("after_to");

        // Byte arriving on the terminal-count cycle is accepted.
        send_byte(8'h33);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("bnd no timeout", 32'(timeout), 32'd0);
        end
        send_byte(8'h44);
        chk("bnd timeout", 32'(timeout), 32'd0);
        chk("bnd b", 32'(alu_b), 32'h44);
        chk("bnd busy", 32'(busy), 32'd0);
        tick();
        chk("bnd timeout+1", 32'(timeout), 32'd0);
        send_byte(8'h20);
        chk("bnd op", 32'(alu_op), 32'h20);
        chk("bnd busy@compute", 32'(busy), 32'd1);
        tick();
        chk("bnd start", 32'(tx_start), 32'd1);
        chk("bnd tx_data", 32'(tx_data), 32'h77);
        tick();
        finish_tx("bnd");

        // Bytes received while busy are dropped.
        run_cmd("busy", 8'h10, 8'h20, 8'h20, 6'h20, 8'h30);
        send_byte(8'h55);
        chk("drop a", 32'(alu_a), 32'h10);
        chk("drop b", 32'(alu_b), 32'h20);
        chk("drop busy", 32'(busy), 32'd1);
        finish_tx("busy");
        run_cmd("post_drop", 8'h02, 8'h02, 8'h20, 6'h20, 8'h04);
        finish_tx("post_drop");

        // Reset in WAIT_OP clears everything; next byte is a fresh A.
        send_byte(8'h09);
        send_byte(8'h08);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst a", 32'(alu_a), 32'd0);
        chk("mrst b", 32'(alu_b), 32'd0);
        chk("mrst op", 32'(alu_op), 32'd0);
        chk("mrst tx_data", 32'(tx_data), 32'd0);
        chk("mrst busy", 32'(busy), 32'd0);
        chk("mrst start", 32'(tx_start), 32'd0);
        send_byte(8'h21);
        chk("mrst fresh a", 32'(alu_a), 32'h21);
        chk("mrst fresh busy", 32'(busy), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("mrst no start", 32'(tx_start), 32'd0);
        end
        send_byte(8'h01);
        send_byte(8'h20);
        chk("mrst op", 32'(alu_op), 32'h20);
        tick();
        chk("mrst start", 32'(tx_start), 32'd1);
        chk("mrst tx", 32'(tx_data), 32'h22);
        tick();
        finish_tx("mrst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
